dcache_miss_handler: RTL and testbench

- Memory-side miss/eviction engine downstream of the direct-mapped write-back dcache controller.
- On a miss the controller hands over the missing line address and, if the victim is dirty, the victim tag and line.
- The block writes the dirty line back as four 32-bit word writes, then fetches the new 128-bit line with one cache-block read.
- It returns the refill line to the controller and pulses done.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_miss_handler.sv | 175 +++++++++++++++++
 tb/tb_dcache_miss_handler.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared data-cache constants and types: memory request size encodings, line
// geometry and the miss handler state type.
// -----------------------------------------------------------------------------
package dcache_pkg;

    // Memory request size encodings understood by the memory side
    localparam logic [2:0] CACHE_MEM_REQ_SIZE_FOUR_BYTES = 3'b010;
    localparam logic [2:0] CACHE_MEM_REQ_SIZE_CACHEBLOCK = 3'b111;

    // Default line geometry
    localparam int unsigned DCACHE_XLEN            = 32;
    localparam int unsigned DCACHE_LINE_WIDTH      = 128;
    localparam int unsigned DCACHE_WORDS_PER_LINE  = DCACHE_LINE_WIDTH / DCACHE_XLEN;

    typedef enum logic [2:0] {
        MISS_IDLE,
        WB_REQ,
        WB_DRAIN,
        REFILL_REQ,
        REFILL_WAIT,
        MISS_DONE
    } miss_state_t;

endpackage

// File: rtl/dcache_miss_handler.sv
// -----------------------------------------------------------------------------
// dcache_miss_handler
// Memory-side miss/eviction engine for the direct-mapped write-back dcache.
// Accepts a miss from the controller, writes back a dirty victim as word
// writes, waits for every write completion, then fetches the new line with a
// single cache-block read and returns it with a one-cycle done pulse.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   miss_valid_i/miss_ready_o  miss handshake (ready only when idle)
//   miss_addr_i                missing address (offset bits ignored)
//   miss_evict_i               victim dirty, write-back required
//   victim_tag_i/victim_line_i victim tag and data
//   miss_done_o                one-cycle pulse, refill_line_o valid
//   refill_line_o              line returned from memory
//   mem_req_o/mem_ack_i        memory request handshake
//   mem_we_o, mem_addr_o, mem_size_o, mem_wdata_o, mem_be_o  request fields
//   mem_rtrn_vld_i, mem_rtrn_write_i, mem_rtrn_data_i        memory returns
// -----------------------------------------------------------------------------
module dcache_miss_handler
    import dcache_pkg::*;
#(
    parameter int unsigned PLEN        = 34,
    parameter int unsigned XLEN        = DCACHE_XLEN,
    parameter int unsigned LINE_WIDTH  = DCACHE_LINE_WIDTH,
    parameter int unsigned INDEX_WIDTH = 12,
    parameter int unsigned TAG_WIDTH   = PLEN - INDEX_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [PLEN-1:0]       miss_addr_i,
    input  logic                  miss_evict_i,
    input  logic [TAG_WIDTH-1:0]  victim_tag_i,
    input  logic [LINE_WIDTH-1:0] victim_line_i,
    output logic                  miss_done_o,
    output logic [LINE_WIDTH-1:0] refill_line_o,
    output logic                  mem_req_o,
    input  logic                  mem_ack_i,
    output logic                  mem_we_o,
    output logic [PLEN-1:0]       mem_addr_o,
    output logic [2:0]            mem_size_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    output logic [XLEN/8-1:0]     mem_be_o,
    input  logic                  mem_rtrn_vld_i,
    input  logic                  mem_rtrn_write_i,
    input  logic [LINE_WIDTH-1:0] mem_rtrn_data_i
);

    localparam int unsigned WORDS      = LINE_WIDTH / XLEN;
    localparam int unsigned CNT_W      = $clog2(WORDS);
    localparam int unsigned LINE_OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int unsigned WORD_OFF_W = $clog2(XLEN / 8);

    miss_state_t                 r_state;
    miss_state_t                 w_state_nxt;
    logic [PLEN-LINE_OFF_W-1:0]  r_line_hi;
    logic [TAG_WIDTH-1:0]        r_victim_tag;
    logic [LINE_WIDTH-1:0]       r_victim_line;
    logic [CNT_W-1:0]            r_word_cnt;
    logic [2:0]                  r_pending;
    logic [2:0]                  w_pending_nxt;
    logic [LINE_WIDTH-1:0]       r_refill_line;

    logic w_accept;
    logic w_wb_ack;
    logic w_wr_rtrn;
    logic w_refill_hit;
    logic w_unused_offset;

    // Offset bits of the miss address select nothing: the whole line moves.
    assign w_unused_offset = ^miss_addr_i[LINE_OFF_W-1:0];

    assign w_accept     = miss_valid_i && (r_state == MISS_IDLE);
    assign w_wb_ack     = (r_state == WB_REQ) && mem_ack_i;
    // Write completions with nothing outstanding are dropped (saturate at 0).
    assign w_wr_rtrn    = mem_rtrn_vld_i && mem_rtrn_write_i && (r_pending != 3'd0);
    assign w_refill_hit = (r_state == REFILL_WAIT) && mem_rtrn_vld_i && !mem_rtrn_write_i;

    assign refill_line_o = r_refill_line;

    always_comb begin
        w_pending_nxt = r_pending;
        case ({w_wb_ack, w_wr_rtrn})
            2'b10:   w_pending_nxt = r_pending + 3'd1;
            2'b01:   w_pending_nxt = r_pending - 3'd1;
            default: w_pending_nxt = r_pending;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        miss_ready_o = 1'b0;
        miss_done_o  = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_size_o   = '0;
        mem_wdata_o  = '0;
        mem_be_o     = '0;
        case (r_state)
            MISS_IDLE: begin
                miss_ready_o = 1'b1;
                if (w_accept) begin
                    w_state_nxt = miss_evict_i ? WB_REQ : REFILL_REQ;
                end
            end
            WB_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_size_o  = CACHE_MEM_REQ_SIZE_FOUR_BYTES;
                mem_addr_o  = {r_victim_tag, r_line_hi[INDEX_WIDTH-LINE_OFF_W-1:0],
                               r_word_cnt, {WORD_OFF_W{1'b0}}};
                mem_wdata_o = r_victim_line[32'(r_word_cnt) * XLEN +: XLEN];
                mem_be_o    = '1;
                if (mem_ack_i && (r_word_cnt == CNT_W'(WORDS - 1))) begin
                    w_state_nxt = WB_DRAIN;
                end
            end
            WB_DRAIN: begin
                // Looking at the next count lets the read issue the cycle
                // after the final write completion instead of one later.
                if (w_pending_nxt == 3'd0) begin
                    w_state_nxt = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                mem_req_o  = 1'b1;
                mem_size_o = CACHE_MEM_REQ_SIZE_CACHEBLOCK;
                mem_addr_o = {r_line_hi, {LINE_OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    w_state_nxt = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (w_refill_hit) begin
                    w_state_nxt = MISS_DONE;
                end
            end
            MISS_DONE: begin
                miss_done_o = 1'b1;
                w_state_nxt = MISS_IDLE;
            end
            default: w_state_nxt = MISS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= MISS_IDLE;
            r_line_hi     <= '0;
            r_victim_tag  <= '0;
            r_victim_line <= '0;
            r_word_cnt    <= '0;
            r_pending     <= '0;
            r_refill_line <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_accept) begin
                r_line_hi     <= miss_addr_i[PLEN-1:LINE_OFF_W];
                r_victim_tag  <= victim_tag_i;
                r_victim_line <= victim_line_i;
                r_word_cnt    <= '0;
            end else if (w_wb_ack) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
            if (w_refill_hit) begin
                r_refill_line <= mem_rtrn_data_i;
            end
        end
    end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// -----------------------------------------------------------------------------
// tb_dcache_miss_handler
// Bench for dcache_miss_handler: a memory responder with configurable ack and
// return delays logs every accepted request; each test compares the log, the
// refill data and done pulses against a transaction-level model of a miss.
// -----------------------------------------------------------------------------
module tb_dcache_miss_handler;

    typedef struct {
        logic        we;
        logic [33:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [3:0]  be;
        int unsigned start_cyc;
        int unsigned ack_cyc;
    } req_t;

    typedef struct {
        int unsigned  due;
        logic         write;
        logic [127:0] data;
    } ret_t;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         miss_valid_i = 1'b0;
    logic         miss_ready_o;
    logic [33:0]  miss_addr_i = '0;
    logic         miss_evict_i = 1'b0;
    logic [21:0]  victim_tag_i = '0;
    logic [127:0] victim_line_i = '0;
    logic         miss_done_o;
    logic [127:0] refill_line_o;
    logic         mem_req_o;
    logic         mem_ack_i = 1'b0;
    logic         mem_we_o;
    logic [33:0]  mem_addr_o;
    logic [2:0]   mem_size_o;
    logic [31:0]  mem_wdata_o;
    logic [3:0]   mem_be_o;
    logic         mem_rtrn_vld_i = 1'b0;
    logic         mem_rtrn_write_i = 1'b0;
    logic [127:0] mem_rtrn_data_i = '0;

    dcache_miss_handler #(
        .PLEN(34), .XLEN(32), .LINE_WIDTH(128), .INDEX_WIDTH(12)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
        .miss_addr_i(miss_addr_i), .miss_evict_i(miss_evict_i),
        .victim_tag_i(victim_tag_i), .victim_line_i(victim_line_i),
        .miss_done_o(miss_done_o), .refill_line_o(refill_line_o),
        .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_size_o(mem_size_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_write_i(mem_rtrn_write_i),
        .mem_rtrn_data_i(mem_rtrn_data_i)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Responder configuration and observations
    int unsigned  ack_delay [5];
    int unsigned  cmpl_delay = 0;
    int unsigned  rd_delay = 0;
    logic [127:0] rd_data = '0;
    int unsigned  req_idx = 0;
    int unsigned  wait_cnt = 0;
    int unsigned  cur_start = 0;
    int unsigned  last_cmpl_cyc = 0;
    int unsigned  done_cnt = 0;
    int unsigned  stab_viol = 0;
    logic [2:0]   pend_snap = '0;
    req_t         log_q[$];
    ret_t         ret_q[$];

    bit           hold_chk = 1'b0;
    logic [33:0]  h_addr;
    logic [31:0]  h_wdata;
    logic [2:0]   h_size;
    logic         h_we;

    always @(negedge clk) begin
        req_t        e;
        ret_t        r;
        int unsigned k;
        mem_ack_i        = 1'b0;
        mem_rtrn_vld_i   = 1'b0;
        mem_rtrn_write_i = 1'b0;
        mem_rtrn_data_i  = '0;
        if (miss_done_o) done_cnt++;
        if (hold_chk) begin
            if (!mem_req_o || mem_addr_o !== h_addr || mem_wdata_o !== h_wdata ||
                mem_size_o !== h_size || mem_we_o !== h_we) stab_viol++;
            hold_chk = 1'b0;
        end
        if (rst_ni && mem_req_o) begin
            if (wait_cnt == 0) cur_start = cyc;
            k = (req_idx > 4) ? 4 : req_idx;
            if (wait_cnt >= ack_delay[k]) begin
                mem_ack_i = 1'b1;
                if (req_idx == 2) pend_snap = dut.r_pending;
                e.we = mem_we_o; e.addr = mem_addr_o; e.wdata = mem_wdata_o;
                e.size = mem_size_o; e.be = mem_be_o;
                e.start_cyc = cur_start; e.ack_cyc = cyc;
                log_q.push_back(e);
                r.write = mem_we_o;
                r.data  = mem_we_o ? 128'h0 : rd_data;
                r.due   = cyc + 1 + (mem_we_o ? cmpl_delay : rd_delay);
                ret_q.push_back(r);
                req_idx++;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                hold_chk = 1'b1;
                h_addr = mem_addr_o; h_wdata = mem_wdata_o;
                h_size = mem_size_o; h_we = mem_we_o;
            end
        end else begin
            wait_cnt = 0;
        end
        if (rst_ni) begin
            for (int i = 0; i < ret_q.size(); i++) begin
                if (ret_q[i].due <= cyc) begin
                    mem_rtrn_vld_i   = 1'b1;
                    mem_rtrn_write_i = ret_q[i].write;
                    mem_rtrn_data_i  = ret_q[i].data;
                    if (ret_q[i].write) last_cmpl_cyc = cyc;
                    ret_q.delete(i);
                    break;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_delays(input int unsigned a, input int unsigned c, input int unsigned rd);
        for (int i = 0; i < 5; i++) ack_delay[i] = a;
        cmpl_delay = c;
        rd_delay   = rd;
    endtask

    // Request the model expects as the idx-th memory transaction of a miss.
    function automatic req_t model_req(input logic [33:0] a, input logic e,
                                       input logic [21:0] t, input logic [127:0] l,
                                       input int unsigned idx);
        req_t r;
        r.start_cyc = 0;
        r.ack_cyc   = 0;
        if (e && idx < 4) begin
            r.we    = 1'b1;
            r.addr  = (34'(t) << 12) + (a & 34'hFF0) + 34'(idx * 4);
            r.wdata = 32'(l >> (32 * idx));
            r.size  = 3'b010;
            r.be    = 4'hF;
        end else begin
            r.we    = 1'b0;
            r.addr  = a & ~34'hF;
            r.wdata = '0;
            r.size  = 3'b111;
            r.be    = '0;
        end
        return r;
    endfunction

    // Reads carry no meaningful data/byte enables; mask them for comparison.
    function automatic logic [73:0] req_key(input req_t r);
        return r.we ? {1'b1, r.addr, r.wdata, r.size, r.be}
                    : {1'b0, r.addr, 32'h0, r.size, 4'h0};
    endfunction

    task automatic do_miss(input logic [33:0] a, input logic e, input logic [21:0] t,
                           input logic [127:0] l, input logic [127:0] d,
                           output bit got, output int unsigned lat,
                           output logic [127:0] refl, output int unsigned ndone);
        int unsigned a_cyc;
        int unsigned d0;
        req_idx = 0;
        log_q.delete();
        rd_data = d;
        d0 = done_cnt;
        got = 1'b0;
        lat = 0;
        refl = '0;
        miss_valid_i  = 1'b1;
        miss_addr_i   = a;
        miss_evict_i  = e;
        victim_tag_i  = t;
        victim_line_i = l;
        a_cyc = cyc;
        tick();
        miss_valid_i = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            if (miss_done_o) begin
                got  = 1'b1;
                lat  = cyc - a_cyc;
                refl = refill_line_o;
            end else begin
                tick();
            end
        end
        tick();
        tick();
        ndone = done_cnt - d0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        chk_cnt++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_size_o, mem_wdata_o, mem_be_o,
             miss_done_o, refill_line_o} !== '0)
            $display("FAIL reset_outputs: got req=%b addr=%h size=%b done=%b refill=%h want all zero",
                     mem_req_o, mem_addr_o, mem_size_o, miss_done_o, refill_line_o);
        else pass_cnt++;
        chk_cnt++;
        if (miss_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", miss_ready_o);
        else pass_cnt++;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_clean_miss();
        bit got; int unsigned lat; logic [127:0] refl; int unsigned nd;
        logic [127:0] d = 128'h0123456789ABCDEF0123456789ABCDEF;
        set_delays(0, 0, 0);
        do_miss(34'h0_0000_1238, 1'b0, 22'h0, '0, d, got, lat, refl, nd);
        chk_cnt++;
        if (log_q.size() != 1) $display("FAIL clean_req_count: got %0d want 1", log_q.size());
        else pass_cnt++;
        if (log_q.size() >= 1) begin
            chk_cnt++;
            if ({log_q[0].we, log_q[0].addr, log_q[0].size} !== {1'b0, 34'h1230, 3'b111})
                $display("FAIL clean_read_req: got we=%b addr=%h size=%b want we=0 addr=1230 size=111",
                         log_q[0].we, log_q[0].addr, log_q[0].size);
            else pass_cnt++;
        end
        chk_cnt++;
        if (refl !== d) $display("FAIL clean_refill: got %h want %h", refl, d);
        else pass_cnt++;
        chk_cnt++;
        if (nd != 1) $display("FAIL clean_done_pulses: got %0d want 1", nd);
        else pass_cnt++;
        chk_cnt++;
        if (!got || lat != 3) $display("FAIL clean_latency: got %0d (seen %b) want 3", lat, got);
        else pass_cnt++;
    endtask

    task automatic test_dirty_miss();
        bit got; int unsigned lat; logic [127:0] refl; int unsigned nd;
        logic [33:0] exp_addr [4] = '{34'hABC230, 34'hABC234, 34'hABC238, 34'hABC23C};
        logic [31:0] exp_data [4] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
        logic [127:0] d = 128'hFEED_0000_1111_2222_3333_4444_5555_6666;
        set_delays(0, 0, 0);
        do_miss(34'h1230, 1'b1, 22'h00ABC,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, d, got, lat, refl, nd);
        chk_cnt++;
        if (log_q.size() != 5) $display("FAIL dirty_req_count: got %0d want 5", log_q.size());
        else pass_cnt++;
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk_cnt++;
            if ({log_q[i].we, log_q[i].addr, log_q[i].wdata, log_q[i].size, log_q[i].be} !==
                {1'b1, exp_addr[i], exp_data[i], 3'b010, 4'hF})
                $display("FAIL dirty_write%0d: got we=%b addr=%h data=%h size=%b be=%h want addr=%h data=%h",
                         i, log_q[i].we, log_q[i].addr, log_q[i].wdata, log_q[i].size, log_q[i].be,
                         exp_addr[i], exp_data[i]);
            else pass_cnt++;
        end
        if (log_q.size() == 5) begin
            chk_cnt++;
            if ({log_q[4].we, log_q[4].addr, log_q[4].size} !== {1'b0, 34'h1230, 3'b111})
                $display("FAIL dirty_read: got we=%b addr=%h size=%b want read 1230",
                         log_q[4].we, log_q[4].addr, log_q[4].size);
            else pass_cnt++;
        end
        chk_cnt++;
        if (!got || refl !== d || nd != 1)
            $display("FAIL dirty_refill: got %h pulses=%0d want %h pulses=1", refl, nd, d);
        else pass_cnt++;
    endtask

    task automatic test_drain_order();
        bit got; int unsigned lat; logic [127:0] refl; int unsigned nd;
        set_delays(0, 10, 0);
        do_miss(34'h2_0000_4560, 1'b1, 22'h12345, {4{32'h5A5A_0F0F}}, 128'h77, got, lat, refl, nd);
        chk_cnt++;
        if (log_q.size() != 5 || log_q[4].we !== 1'b0)
            $display("FAIL drain_req_count: got %0d want 5 ending in a read", log_q.size());
        else pass_cnt++;
        if (log_q.size() == 5) begin
            chk_cnt++;
            if (log_q[4].start_cyc != last_cmpl_cyc + 1)
                $display("FAIL drain_read_timing: got read at cycle %0d want %0d (last completion %0d)",
                         log_q[4].start_cyc, last_cmpl_cyc + 1, last_cmpl_cyc);
            else pass_cnt++;
        end
        chk_cnt++;
        if (!got || nd != 1 || refl !== 128'h77)
            $display("FAIL drain_done: got refill=%h pulses=%0d want 77 pulses=1", refl, nd);
        else pass_cnt++;
        set_delays(0, 0, 0);
    endtask

    task automatic test_backpressure();
        bit got; int unsigned lat; logic [127:0] refl; int unsigned nd;
        req_t exp_r;
        logic [127:0] l = 128'h44444444_33333333_22222222_11111111;
        set_delays(0, 0, 0);
        ack_delay[2] = 5;
        stab_viol = 0;
        do_miss(34'h3_0000_0ABC, 1'b1, 22'h3FFFF, l, 128'h99, got, lat, refl, nd);
        chk_cnt++;
        if (stab_viol != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_viol);
        else pass_cnt++;
        if (log_q.size() >= 3) begin
            chk_cnt++;
            if (log_q[2].ack_cyc - log_q[2].start_cyc != 5)
                $display("FAIL bp_hold_cycles: got %0d want 5", log_q[2].ack_cyc - log_q[2].start_cyc);
            else pass_cnt++;
            exp_r = model_req(34'h3_0000_0ABC, 1'b1, 22'h3FFFF, l, 2);
            chk_cnt++;
            if (req_key(log_q[2]) !== req_key(exp_r))
                $display("FAIL bp_word2: got addr=%h data=%h want addr=%h data=%h",
                         log_q[2].addr, log_q[2].wdata, exp_r.addr, exp_r.wdata);
            else pass_cnt++;
        end else begin
            chk_cnt++;
            $display("FAIL bp_req_count: got %0d want >=3", log_q.size());
        end
        set_delays(0, 0, 0);
    endtask

    task automatic test_simult_ack();
        bit got; int unsigned lat; logic [127:0] refl; int unsigned nd;
        set_delays(0, 0, 0);
        pend_snap = 3'd7;
        do_miss(34'h1_2345_6780, 1'b1, 22'h0F0F0, {4{32'hCAFEBABE}}, 128'h5, got, lat, refl, nd);
        chk_cnt++;
        if (pend_snap !== 3'd1)
            $display("FAIL simult_pending: got %0d want 1", pend_snap);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        ret_t r;
        int unsigned d0 = done_cnt;
        r.due = cyc; r.write = 1'b1; r.data = '0;
        ret_q.push_back(r);
        tick();
        tick();
        chk_cnt++;
        if (dut.r_pending !== 3'd0 || miss_ready_o !== 1'b1 || done_cnt != d0)
            $display("FAIL stray_write_return: got pending=%0d ready=%b want pending=0 ready=1",
                     dut.r_pending, miss_ready_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_refill_wait();
        bit seen = 1'b0;
        int unsigned d0;
        set_delays(0, 0, 15);
        req_idx = 0;
        log_q.delete();
        rd_data = 128'hBAD0BAD0;
        miss_valid_i = 1'b1;
        miss_addr_i  = 34'h5670;
        miss_evict_i = 1'b0;
        tick();
        miss_valid_i = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (log_q.size() == 1) seen = 1'b1;
            else tick();
        end
        chk_cnt++;
        if (!seen) $display("FAIL rst_wait_read: got no read request want one");
        else pass_cnt++;
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk_cnt++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_size_o, mem_wdata_o, mem_be_o,
             miss_done_o, refill_line_o} !== '0 || miss_ready_o !== 1'b1)
            $display("FAIL rst_in_wait: got req=%b addr=%h done=%b ready=%b want zeros and ready=1",
                     mem_req_o, mem_addr_o, miss_done_o, miss_ready_o);
        else pass_cnt++;
        tick();
        tick();
        rst_ni = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 30; i++) tick();
        chk_cnt++;
        if (done_cnt != d0 || ret_q.size() != 0)
            $display("FAIL rst_stray_return: got pulses=%0d undelivered=%0d want 0 and 0",
                     done_cnt - d0, ret_q.size());
        else pass_cnt++;
        set_delays(0, 0, 0);
    endtask

    task automatic test_random();
        bit got; int unsigned lat; logic [127:0] refl; int unsigned nd;
        logic [33:0] a; logic e; logic [21:0] t; logic [127:0] l; logic [127:0] d;
        req_t exp_r;
        int unsigned n_exp;
        int unsigned bad;
        for (int it = 0; it < 20; it++) begin
            a = {2'($urandom_range(0, 3)), 32'($urandom)};
            e = 1'($urandom);
            t = 22'($urandom);
            l = {$urandom, $urandom, $urandom, $urandom};
            d = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 5; i++) ack_delay[i] = $urandom_range(0, 3);
            cmpl_delay = $urandom_range(0, 4);
            rd_delay   = $urandom_range(0, 3);
            do_miss(a, e, t, l, d, got, lat, refl, nd);
            n_exp = e ? 5 : 1;
            bad = 0;
            if (log_q.size() != n_exp) bad++;
            else
                for (int i = 0; i < n_exp; i++) begin
                    exp_r = model_req(a, e, t, l, i);
                    if (req_key(log_q[i]) !== req_key(exp_r)) bad++;
                end
            chk_cnt++;
            if (bad != 0) $display("FAIL rand%0d_requests: got %0d bad of %0d (want %0d reqs) addr=%h evict=%b",
                                   it, bad, log_q.size(), n_exp, a, e);
            else pass_cnt++;
            chk_cnt++;
            if (!got || refl !== d || nd != 1)
                $display("FAIL rand%0d_refill: got %h pulses=%0d want %h pulses=1", it, refl, nd, d);
            else pass_cnt++;
            if (e && log_q.size() == 5) begin
                chk_cnt++;
                if (log_q[4].start_cyc != last_cmpl_cyc + 1)
                    $display("FAIL rand%0d_order: got read at %0d want %0d", it,
                             log_q[4].start_cyc, last_cmpl_cyc + 1);
                else pass_cnt++;
            end
        end
        set_delays(0, 0, 0);
    endtask

    initial begin
        set_delays(0, 0, 0);
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_drain_order();
        test_backpressure();
        test_simult_ack();
        test_saturate();
        test_reset_in_refill_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
